// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types for the FIFO write arbiter and its round-robin picker.
// Latency: n/a (declarations and a combinational helper only).
// Backpressure: n/a.
//
// Contents: arb_state_e (arbiter FSM states), onehot_to_idx (one-hot to binary).
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Encodes a one-hot vector of up to 16 bits into its bit position.
    // OR-based encode so a single set bit maps cleanly with no priority chain.
    function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) begin
                idx = idx | 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of requester handshakes and FIFO write-port signals for fifo_wr_arbiter.
// Latency: n/a (wires only).
// Backpressure: o_req_ready per requester; i_fifo_full / i_fifo_alm_full from the FIFO.
//
// master: arbiter side (drives ready/grant/FIFO write/busy).
// slave : environment side (drives requests and FIFO status).
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 128
);
    logic [NUM_REQ-1:0]        i_req_valid;
    logic [NUM_REQ*DATA_W-1:0] i_req_data;
    logic [NUM_REQ-1:0]        o_req_ready;
    logic [NUM_REQ-1:0]        o_grant;
    logic                      o_fifo_wren;
    logic [DATA_W-1:0]         o_fifo_wrdata;
    logic                      i_fifo_full;
    logic                      i_fifo_alm_full;
    logic                      o_busy;

    modport master (
        input  i_req_valid, i_req_data, i_fifo_full, i_fifo_alm_full,
        output o_req_ready, o_grant, o_fifo_wren, o_fifo_wrdata, o_busy
    );

    modport slave (
        output i_req_valid, i_req_data, i_fifo_full, i_fifo_alm_full,
        input  o_req_ready, o_grant, o_fifo_wren, o_fifo_wrdata, o_busy
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set request strictly after ptr, wrapping modulo NUM_REQ.
// Latency: combinational.
// Backpressure: none; caller decides whether to act on the pick.
//
// Ports: req (request vector), ptr (last served index),
//        winner (one-hot), idx (binary winner), found (any request set).
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    int               pos;
    logic [IDX_W-1:0] pidx;

    // Explicit wrap instead of a power-of-two mask so odd NUM_REQ works.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        pos    = 0;
        pidx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            pos = int'(ptr) + i;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            pidx = IDX_W'(pos);
            if (!found && req[pidx]) begin
                winner[pidx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    assign idx = IDX_W'(onehot_to_idx(16'(winner)));

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters, bursts of up to MAX_BURST beats.
// Latency: grant 1 cycle after valid seen in IDLE; data passes to the FIFO with zero latency during GRANT.
// Backpressure: new grants held off by i_fifo_alm_full; beats stalled (ready=0) while i_fifo_full.
//
// Ports: clk, rstn (synchronous, active-low), bus (fifo_wr_arbiter_if.master):
//   i_req_valid/i_req_data/o_req_ready per requester, o_grant one-hot,
//   o_fifo_wren/o_fifo_wrdata to the FIFO, i_fifo_full/i_fifo_alm_full from it, o_busy.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 128,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rstn,
    fifo_wr_arbiter_if.master bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   gidx_q,  gidx_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [IDX_W-1:0]   ptr_q,   ptr_d;

    logic [NUM_REQ-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;

    logic               in_grant;
    logic               may_write;
    logic               beat;
    logic               g_valid;
    logic [DATA_W-1:0]  g_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (bus.i_req_valid),
        .ptr    (ptr_q),
        .winner (pick_oh),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    // Select the granted requester's valid and data.
    always_comb begin
        g_valid = 1'b0;
        g_data  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gidx_q == IDX_W'(k)) begin
                g_valid = bus.i_req_valid[k];
                g_data  = bus.i_req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign in_grant  = (state_q == ARB_GRANT);
    // rstn gates the write path so a beat coincident with reset is never
    // committed to the FIFO while the arbiter itself discards it.
    assign may_write = in_grant & ~bus.i_fifo_full & rstn;
    assign beat      = may_write & g_valid;

    assign bus.o_req_ready   = may_write ? grant_q : '0;
    assign bus.o_grant       = grant_q;
    assign bus.o_fifo_wren   = beat;
    assign bus.o_fifo_wrdata = in_grant ? g_data : '0;
    assign bus.o_busy        = in_grant;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found && !bus.i_fifo_alm_full) begin
                    state_d = ARB_GRANT;
                    grant_d = pick_oh;
                    gidx_d  = pick_idx;
                    cnt_d   = '0;
                end
            end
            ARB_GRANT: begin
                // Dropping valid forfeits the grant even while the FIFO is full.
                if (!g_valid || (beat && cnt_q == LAST_BEAT)) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                    ptr_d   = gidx_q;
                end else if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            cnt_q   <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter (NUM_REQ=4, DATA_W=16, MAX_BURST=4).
// Requester k presents data {k, 4'h0, d} where d is the per-row byte.
// Table rows give inputs for one cycle and the outputs expected during that cycle.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ   (N),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic        rstn;
        logic [3:0]  vld;
        logic [7:0]  d;
        logic        full;
        logic        alm;
        logic [3:0]  grant;
        logic [3:0]  rdy;
        logic        wren;
        logic [15:0] wdat;
        logic        busy;
    } vec_t;

    localparam int NV = 45;
    vec_t vt[NV];

    int tests = 0;
    int fails = 0;

    function automatic vec_t mk(input logic r, input logic [3:0] vld, input logic [7:0] d,
                                input logic f, input logic a, input logic [3:0] g,
                                input logic [3:0] rd, input logic w, input logic [15:0] wd,
                                input logic b);
        vec_t v;
        v.rstn = r; v.vld = vld; v.d = d; v.full = f; v.alm = a;
        v.grant = g; v.rdy = rd; v.wren = w; v.wdat = wd; v.busy = b;
        return v;
    endfunction

    task automatic apply(input logic r, input logic [3:0] vld, input logic [7:0] d,
                         input logic f, input logic a);
        logic [N*DW-1:0] dat;
        for (int k = 0; k < N; k++) begin
            dat[k*DW +: DW] = {4'(k), 4'h0, d};
        end
        rstn                = r;
        bus.i_req_valid     = vld;
        bus.i_req_data      = dat;
        bus.i_fifo_full     = f;
        bus.i_fifo_alm_full = a;
    endtask

    task automatic chk(input string name, input int row, input logic [15:0] act,
                       input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s row %0d: got %h, expected %h", name, row, act, exp);
        end
    endtask

    initial begin
        int t;
        int beats;
        logic [3:0] fair_exp [8];

        // Reset/all-valid, then requesters 0 and 1 alternate with 4-beat bursts.
        vt[0]  = mk(1, 4'hF, 8'h00, 0, 0, 4'h0, 4'h0, 0, 16'h0000, 0);
        vt[1]  = mk(1, 4'h3, 8'h01, 0, 0, 4'h1, 4'h1, 1, 16'h0001, 1);
        vt[2]  = mk(1, 4'h3, 8'h02, 0, 0, 4'h1, 4'h1, 1, 16'h0002, 1);
        vt[3]  = mk(1, 4'h3, 8'h03, 0, 0, 4'h1, 4'h1, 1, 16'h0003, 1);
        vt[4]  = mk(1, 4'h3, 8'h04, 0, 0, 4'h1, 4'h1, 1, 16'h0004, 1);
        vt[5]  = mk(1, 4'h3, 8'h05, 0, 0, 4'h0, 4'h0, 0, 16'h0000, 0);
        vt[6]  = mk(1, 4'h3, 8'h06, 0, 0, 4'h2, 4'h2, 1, 16'h1006, 1);
        vt[7]  = mk(1, 4'h3, 8'h07, 0, 0, 4'h2, 4'h2, 1, 16'h1007, 1);
        vt[8]  = mk(1, 4'h3, 8'h08, 0, 0, 4'h2, 4'h2, 1, 16'h1008, 1);
        vt[9]  = mk(1, 4'h3, 8'h09, 0, 0, 4'h2, 4'h2, 1, 16'h1009, 1);
        vt[10] = mk(1, 4'h3, 8'h0A, 0, 0, 4'h0, 4'h0, 0, 16'h0000, 0);
        vt[11] = mk(1, 4'h3, 8'h0B, 0, 0, 4'h1, 4'h1, 1, 16'h000B, 1);
        vt[12] = mk(1, 4'h0, 8'h0C, 0, 0, 4'h1, 4'h1, 0, 16'h000C, 1);
        vt[13] = mk(1, 4'h0, 8'h0C, 0, 0, 4'h0, 4'h0, 0, 16'h0000, 0);
        // Requester 2: three beats then valid drop.
        vt[14] = mk(1, 4'h4, 8'hA1, 0, 0, 4'h0, 4'h0, 0, 16'h0000, 0);
        vt[15] = mk(1, 4'h4, 8'hA1, 0, 0, 4'h4, 4'h4, 1, 16'h20A1, 1);
        vt[16] = mk(1, 4'h4, 8'hA2, 0, 0, 4'h4, 4'h4, 1, 16'h20A2, 1);
        vt[17] = mk(1, 4'h4, 8'hA3, 0, 0, 4'h4, 4'h4, 1, 16'h20A3, 1);
        vt[18] = mk(1, 4'h0, 8'hA3, 0, 0, 4'h4, 4'h4, 0, 16'h20A3, 1);
        vt[19] = mk(1, 4'h0, 8'hA3, 0, 0, 4'h0, 4'h0, 0, 16'h0000, 0);
        // Requester 1 with a 3-cycle full stall after the first beat.
        vt[20] = mk(1, 4'h2, 8'hB1, 0, 0, 4'h0, 4'h0, 0, 16'h0000, 0);
        vt[21] = mk(1, 4'h2, 8'hB1, 0, 0, 4'h2, 4'h2, 1, 16'h10B1, 1);
        vt[22] = mk(1, 4'h2, 8'hB2, 1, 0, 4'h2, 4'h0, 0, 16'h10B2, 1);
        vt[23] = mk(1, 4'h2, 8'hB2, 1, 0, 4'h2, 4'h0, 0, 16'h10B2, 1);
        vt[24] = mk(1, 4'h2, 8'hB2, 1, 0, 4'h2, 4'h0, 0, 16'h10B2, 1);
        vt[25] = mk(1, 4'h2, 8'hB2, 0, 0, 4'h2, 4'h2, 1, 16'h10B2, 1);
        vt[26] = mk(1, 4'h2, 8'hB3, 0, 0, 4'h2, 4'h2, 1, 16'h10B3, 1);
        vt[27] = mk(1, 4'h2, 8'hB4, 0, 0, 4'h2, 4'h2, 1, 16'h10B4, 1);
        vt[28] = mk(1, 4'h0, 8'hB4, 0, 0, 4'h0, 4'h0, 0, 16'h0000, 0);
        // Almost-full throttle on requester 3, then valid drop while full.
        vt[29] = mk(1, 4'h8, 8'hC1, 0, 1, 4'h0, 4'h0, 0, 16'h0000, 0);
        vt[30] = mk(1, 4'h8, 8'hC1, 0, 1, 4'h0, 4'h0, 0, 16'h0000, 0);
        vt[31] = mk(1, 4'h8, 8'hC1, 0, 0, 4'h0, 4'h0, 0, 16'h0000, 0);
        vt[32] = mk(1, 4'h8, 8'hC1, 0, 1, 4'h8, 4'h8, 1, 16'h30C1, 1);
        vt[33] = mk(1, 4'h0, 8'hC2, 1, 0, 4'h8, 4'h0, 0, 16'h30C2, 1);
        vt[34] = mk(1, 4'h0, 8'hC2, 0, 0, 4'h0, 4'h0, 0, 16'h0000, 0);
        // Move pointer to 1, then reset in the middle of a requester-2 burst.
        vt[35] = mk(1, 4'h2, 8'hD0, 0, 0, 4'h0, 4'h0, 0, 16'h0000, 0);
        vt[36] = mk(1, 4'h0, 8'hD0, 0, 0, 4'h2, 4'h2, 0, 16'h10D0, 1);
        vt[37] = mk(1, 4'h4, 8'hD1, 0, 0, 4'h0, 4'h0, 0, 16'h0000, 0);
        vt[38] = mk(1, 4'h4, 8'hD1, 0, 0, 4'h4, 4'h4, 1, 16'h20D1, 1);
        vt[39] = mk(1, 4'h4, 8'hD2, 0, 0, 4'h4, 4'h4, 1, 16'h20D2, 1);
        vt[40] = mk(0, 4'h4, 8'hD3, 0, 0, 4'h4, 4'h0, 0, 16'h20D3, 1);
        vt[41] = mk(1, 4'hF, 8'hD4, 0, 0, 4'h0, 4'h0, 0, 16'h0000, 0);
        vt[42] = mk(1, 4'hF, 8'hD4, 0, 0, 4'h1, 4'h1, 1, 16'h00D4, 1);
        vt[43] = mk(1, 4'h0, 8'hD4, 0, 0, 4'h1, 4'h1, 0, 16'h00D4, 1);
        vt[44] = mk(1, 4'h0, 8'hD4, 0, 0, 4'h0, 4'h0, 0, 16'h0000, 0);

        // Reset held for 2 edges with every requester valid.
        apply(1'b0, 4'hF, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_grant", -1, 16'(bus.o_grant),     16'h0);
        chk("reset_ready", -1, 16'(bus.o_req_ready), 16'h0);
        chk("reset_wren",  -1, 16'(bus.o_fifo_wren), 16'h0);
        chk("reset_busy",  -1, 16'(bus.o_busy),      16'h0);

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            apply(vt[i].rstn, vt[i].vld, vt[i].d, vt[i].full, vt[i].alm);
            #2;
            chk("grant",  i, 16'(bus.o_grant),     16'(vt[i].grant));
            chk("ready",  i, 16'(bus.o_req_ready), 16'(vt[i].rdy));
            chk("wren",   i, 16'(bus.o_fifo_wren), 16'(vt[i].wren));
            chk("wrdata", i, bus.o_fifo_wrdata,    vt[i].wdat);
            chk("busy",   i, 16'(bus.o_busy),      16'(vt[i].busy));
        end

        // All four continuously valid from pointer 0: order 1,2,3,0 twice,
        // 4 beats per grant, exactly one idle cycle between grants.
        fair_exp = '{4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
        apply(1'b1, 4'hF, 8'hEE, 1'b0, 1'b0);
        for (int j = 0; j < 8; j++) begin
            t = 0;
            do begin
                @(posedge clk);
                #2;
                t++;
            end while (!bus.o_busy && t < 10);
            chk("fair_gap",   j, 16'(t),             16'd1);
            chk("fair_grant", j, 16'(bus.o_grant),   16'(fair_exp[j]));
            beats = 0;
            t = 0;
            while (bus.o_busy && t < 20) begin
                if (bus.o_fifo_wren) beats++;
                @(posedge clk);
                #2;
                t++;
            end
            chk("fair_beats", j, 16'(beats), 16'(MB));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one my_fifo write port between NUM_REQ requesters.
- Each requester uses a valid/ready handshake; the block drives the FIFO's i_wren/i_wrdata.
- A grant is held for a burst of up to MAX_BURST beats.
- New grants are throttled by FIFO almost-full; individual beats are stalled by FIFO full.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_W, 128, data width; must match the FIFO's DATA_W.
- MAX_BURST, 8, maximum beats per grant (1..255).

Ports:
- clk  input  1  clock
- rstn  input  1  reset, synchronous, active-low
- i_req_valid  input  NUM_REQ  per-requester data valid
- i_req_data  input  NUM_REQ*DATA_W  requester k occupies bits [k*DATA_W +: DATA_W]
- o_req_ready  output  NUM_REQ  per-requester ready; at most one bit high
- o_grant  output  NUM_REQ  one-hot registered grant; all zero when idle
- o_fifo_wren  output  1  to FIFO i_wren
- o_fifo_wrdata  output  DATA_W  to FIFO i_wrdata
- i_fifo_full  input  1  from FIFO o_full
- i_fifo_alm_full  input  1  from FIFO o_alm_full
- o_busy  output  1  high while in GRANT state

Behaviour:
- Reset (rstn low at a clk edge):
  - state=IDLE, o_grant=0, burst count=0, round-robin pointer=NUM_REQ-1.
  - Therefore o_req_ready=0, o_fifo_wren=0, o_busy=0.
  - Reset mid-burst aborts the burst; the in-flight beat is not written.
- IDLE state:
  - If any i_req_valid is high and i_fifo_alm_full=0: choose the first valid index searching from pointer+1 upward, wrapping modulo NUM_REQ.
  - Register it as o_grant one-hot and go to GRANT.
  - Otherwise stay in IDLE.
  - No transfers occur in IDLE. Grant latency is 1 cycle after valid is seen.
- GRANT state (granted index g):
  - o_req_ready[g] = ~i_fifo_full (combinational); all other ready bits are 0.
  - Beat: i_req_valid[g] & o_req_ready[g].
  - On a beat: o_fifo_wren=1 and o_fifo_wrdata=i_req_data[g] in the same cycle. This is a zero-latency pass-through.
  - Burst count increments on each beat.
  - i_fifo_alm_full is ignored while in GRANT.
  - Release occurs when either:
    - (a) a beat occurs with burst count = MAX_BURST-1, or
    - (b) i_req_valid[g]=0.
  - On release: next state IDLE, o_grant=0, burst count=0, pointer=g.
  - One idle bubble cycle is mandatory between grants.
- o_fifo_wrdata:
  - Equals the granted requester's data while in GRANT.
  - Equals 0 in IDLE.
- FIFO full:
  - While i_fifo_full=1, ready=0 and wren=0. The grant is held; no release occurs unless valid drops.
  - A write is never issued while full, so the FIFO never silently drops a beat.
- Simultaneous valid drop and full: release per rule (b).
- Requester rule: a requester must hold valid and data stable until it sees ready high. A requester that drops valid forfeits its grant.
- Fairness:
  - The pointer advances only on release.
  - Every continuously valid requester is granted within NUM_REQ grants.
- Width rules:
  - Burst count is $clog2(MAX_BURST+1) bits.
  - Pointer and grant index are $clog2(NUM_REQ) bits.
  - Index arithmetic wraps modulo NUM_REQ; this is correct for non-power-of-two NUM_REQ.

Decomposition:
- Package fifo_arb_pkg: state enum arb_state_e {ARB_IDLE, ARB_GRANT}; function onehot_to_idx.
- Sub-module rr_pick:
  - Combinational round-robin picker.
  - Inputs: request vector, pointer.
  - Outputs: one-hot winner, index, found flag.
  - Reusable by a future read scheduler.

Test Plan:
- Reset:
  - Stimulus: rstn=0 for 2 cycles with all valid high.
  - Required: o_grant=0, o_req_ready=0, o_fifo_wren=0, o_busy=0. First grant after release goes to requester 0.
- Single burst (NUM_REQ=4, MAX_BURST=8):
  - Stimulus: requester 2 drives 3 beats (0xA1, 0xA2, 0xA3), then drops valid.
  - Required: grant=4'b0100 one cycle after valid. wren is high for exactly 3 cycles carrying A1..A3. IDLE is reached on the valid-drop cycle.
- Burst limit (MAX_BURST=4):
  - Stimulus: requesters 0 and 1 continuously valid.
  - Required: grants alternate 0,1,0,1. Exactly 4 beats per grant. One bubble cycle between grants.
- Full stall:
  - Stimulus: i_fifo_full=1 for 3 cycles mid-burst.
  - Required: ready=0, wren=0 during the stall. Grant is held. The burst resumes with the same pending data and the total beat count is preserved.
- Almost-full throttle:
  - Stimulus: i_fifo_alm_full=1 in IDLE with requester 3 valid.
  - Required: no grant is issued. Grant to requester 3 occurs one cycle after alm_full falls.
- Reset mid-burst:
  - Stimulus: rstn=0 after 2 beats of a burst.
  - Required: wren=0 from the reset edge onward. State is IDLE and the pointer is NUM_REQ-1.
